fft_ram_writer: RTL and testbench
=================================

# fft_ram_writer

Loads one frame of input samples into an FFT buffer RAM (SB_RAM40_4K write port, 256 x 16) through a valid/ready stream, optionally in bit-reversed address order so the FFT core reads the frame in natural order. It sits between the sample source and the buffer RAM's write side; the FFT core and twiddle logic own the read side. A frame starts on a START pulse, ends after FRAME_LEN accepted samples, and the block holds the frame until the consumer acknowledges it.

## Interface
- ADDR_W, 8: RAM address width (256 words).
- DATA_W, 16: sample and RAM word width.
- FRAME_LEN, 256: samples per frame; power of two, 2..2^ADDR_W.
- BIT_REV, 1: 1 = bit-reversed write addresses, 0 = natural order.
- BASE_ADDR, 0: address offset added to every write address; BASE_ADDR + FRAME_LEN <= 2^ADDR_W.
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  begin a frame (sampled in IDLE, or in DONE together with DONE_ACK).
- S_DATA  in  DATA_W  sample data.
- S_VALID  in  1  sample valid.
- S_READY  out  1  block accepts a sample this cycle.
- WADDR  out  ADDR_W  RAM write address.
- WDATA  out  DATA_W  RAM write data.
- WE  out  1  RAM write enable (WCLK = CLK, MASK tied 0 at top level).
- BUSY  out  1  state is FILL.
- FRAME_DONE  out  1  full frame committed to RAM, held until acknowledged.
- DONE_ACK  in  1  consumer releases the frame.
- SAMPLE_CNT  out  ADDR_W+1  samples accepted in current/last frame.

## Operation
- States: IDLE, FILL, DONE. Reset -> IDLE.
- IDLE: START=1 -> FILL, counter cleared to 0. Otherwise stay.
- FILL: S_READY=1. Each cycle S_VALID & S_READY: capture S_DATA, WADDR = BASE_ADDR + (BIT_REV ? bitrev(cnt, log2(FRAME_LEN)) : cnt), counter +1. When the accepted sample is number FRAME_LEN-1 (zero-based) -> DONE. START in FILL ignored.
- DONE: S_READY=0, FRAME_DONE=1. DONE_ACK=1 -> IDLE; DONE_ACK=1 and START=1 same cycle -> FILL with counter cleared. START alone ignored.
- Counter width ADDR_W+1 so SAMPLE_CNT reaches FRAME_LEN exactly; bit reversal uses only the low log2(FRAME_LEN) bits. No wrap beyond FRAME_LEN: FILL exits before it.
- S_VALID with S_READY=0 is not consumed; source holds data (standard valid/ready, no dropped or duplicated samples).
- Reset mid-frame: all state lost immediately, WE forced 0 asynchronously, partially written RAM contents are don't-care.

## Timing
- Reset values: S_READY=0, WADDR=0, WDATA=0, WE=0, BUSY=0, FRAME_DONE=0, SAMPLE_CNT=0.
- S_READY, BUSY, FRAME_DONE decoded from registered state only (no combinational path from inputs).
- Write latency 1: sample accepted at edge k -> WADDR/WDATA/WE=1 valid during cycle k..k+1, RAM commits at edge k+1. WE=0 in every cycle without a preceding accept.
- Back-to-back throughput 1 sample/cycle; frame of N samples takes N cycles of FILL at full rate.
- Last sample accepted at edge k: state DONE from k, final WE during cycle after k, FRAME_DONE rises at edge k+1 (after last write committed is visible to reader from k+2 in READ_MODE 0).
- SAMPLE_CNT updates at the accept edge; holds FRAME_LEN in DONE and IDLE until next START.

## Structure
- Shared package fft_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, FILL, DONE), clog2 and bitrev(value, width) functions shared with the FFT read sequencer.
- One sub-module: bit_reverse (parameterised width, combinational) producing the reversed address; used here and by the FFT address generator.
- RAM instance stays outside this block.

## Test plan
- FRAME_LEN=8, BIT_REV=1, START then samples 0x0001..0x0008 back-to-back -> writes to addresses 0,4,2,6,1,5,3,7 with data 1..8; FRAME_DONE rises one cycle after the 8th accept; SAMPLE_CNT=8.
- BIT_REV=0, BASE_ADDR=16, FRAME_LEN=4, samples 0xA..0xD -> WADDR 16,17,18,19; no write at address 20.
- Random S_VALID gaps (50%) over a 256-sample frame -> exactly 256 WE pulses, data/address pairs match a reference model, no duplicates.
- DONE state: S_VALID=1 held for 10 cycles -> S_READY=0, WE=0 throughout; DONE_ACK -> IDLE next cycle, FRAME_DONE=0; DONE_ACK+START same cycle -> BUSY=1 next cycle, SAMPLE_CNT=0.
- START pulsed during FILL after 3 samples -> ignored, frame continues from count 3.
- RST_N low after 5 of 8 samples -> WE, S_READY, BUSY drop immediately; after release state IDLE, SAMPLE_CNT=0, new frame writes address 0 first.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, frame-loader state encoding and
// address helpers used by both the RAM writer and the FFT read sequencer.
package fft_pkg;

    localparam int FFT_ADDR_W = 8;
    localparam int FFT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Reverses the low 'width' bits of value; bits above width come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[i] = value[5'(width - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal of a W-bit index (FFT address permutation).
module bit_reverse
    import fft_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    assign out_o = W'(bitrev(32'(in_i), W));

endmodule

// File: rtl/fft_ram_writer.sv
// Streams one frame of samples into the FFT buffer RAM write port, optionally
// in bit-reversed order, and holds the frame until the consumer acknowledges.
module fft_ram_writer
    import fft_pkg::*;
#(
    parameter int ADDR_W    = FFT_ADDR_W,
    parameter int DATA_W    = FFT_DATA_W,
    parameter int FRAME_LEN = 256,
    parameter int BIT_REV   = 1,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [DATA_W-1:0] S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] WDATA,
    output logic              WE,
    output logic              BUSY,
    output logic              FRAME_DONE,
    input  logic              DONE_ACK,
    output logic [ADDR_W:0]   SAMPLE_CNT
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int REV_W = clog2(FRAME_LEN);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;

    logic              accept;
    logic [REV_W-1:0]  idx;
    logic [REV_W-1:0]  rev_idx;
    logic [ADDR_W-1:0] offset;

    assign idx = cnt_q[REV_W-1:0];

    bit_reverse #(.W(REV_W)) u_bit_reverse (
        .in_i (idx),
        .out_o(rev_idx)
    );

    assign offset = (BIT_REV != 0) ? ADDR_W'(rev_idx) : ADDR_W'(idx);
    assign accept = S_VALID && (state_q == FILL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = ADDR_W'(BASE_ADDR) + offset;
                    wdata_d = S_DATA;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = DONE;
                end
            end
            DONE: begin
                if (DONE_ACK) begin
                    if (START) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FRAME_DONE lags DONE entry by one cycle so it only rises once the final write has committed.
    assign done_d = (state_q == DONE) && (state_d == DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    assign S_READY    = (state_q == FILL);
    assign BUSY       = (state_q == FILL);
    assign FRAME_DONE = done_q;
    assign WADDR      = waddr_q;
    assign WDATA      = wdata_q;
    assign WE         = we_q;
    assign SAMPLE_CNT = cnt_q;

endmodule

// File: tb/tb_fft_ram_writer.sv
// Directed bench for fft_ram_writer: an 8-sample bit-reversed instance and a
// 4-sample natural-order instance at base address 16.
module tb_fft_ram_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_start = 1'b0, a_valid = 1'b0, a_ack = 1'b0;
    logic [15:0] a_data = '0;
    logic        a_ready, a_we, a_busy, a_done;
    logic [7:0]  a_waddr;
    logic [15:0] a_wdata;
    logic [8:0]  a_cnt;

    logic        b_start = 1'b0, b_valid = 1'b0, b_ack = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_ready, b_we, b_busy, b_done;
    logic [7:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [8:0]  b_cnt;

    int checks = 0;
    int errors = 0;
    int exp_addr[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    fft_ram_writer #(.ADDR_W(8), .DATA_W(16), .FRAME_LEN(8), .BIT_REV(1), .BASE_ADDR(0)) dut_a (
        .CLK(clk), .RST_N(rst_n), .START(a_start), .S_DATA(a_data), .S_VALID(a_valid),
        .S_READY(a_ready), .WADDR(a_waddr), .WDATA(a_wdata), .WE(a_we), .BUSY(a_busy),
        .FRAME_DONE(a_done), .DONE_ACK(a_ack), .SAMPLE_CNT(a_cnt)
    );

    fft_ram_writer #(.ADDR_W(8), .DATA_W(16), .FRAME_LEN(4), .BIT_REV(0), .BASE_ADDR(16)) dut_b (
        .CLK(clk), .RST_N(rst_n), .START(b_start), .S_DATA(b_data), .S_VALID(b_valid),
        .S_READY(b_ready), .WADDR(b_waddr), .WDATA(b_wdata), .WE(b_we), .BUSY(b_busy),
        .FRAME_DONE(b_done), .DONE_ACK(b_ack), .SAMPLE_CNT(b_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", a_ready); end
        checks++; if (a_waddr !== 8'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", a_waddr); end
        checks++; if (a_wdata !== 16'd0) begin errors++; $display("FAIL reset_wdata got %0h want 0", a_wdata); end
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", a_we); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", a_done); end
        checks++; if (a_cnt !== 9'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bitrev_frame();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %0b want 1", a_busy); end
        checks++; if (a_cnt !== 9'd0) begin errors++; $display("FAIL fill_cnt0 got %0d want 0", a_cnt); end
        a_valid = 1'b1;
        a_data  = 16'h0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (a_we !== 1'b1) begin errors++; $display("FAIL br_we[%0d] got %0b want 1", i, a_we); end
            checks++; if (a_waddr !== 8'(exp_addr[i])) begin errors++; $display("FAIL br_addr[%0d] got %0d want %0d", i, a_waddr, exp_addr[i]); end
            checks++; if (a_wdata !== 16'(i + 1)) begin errors++; $display("FAIL br_data[%0d] got %0h want %0h", i, a_wdata, i + 1); end
            checks++; if (a_cnt !== 9'(i + 1)) begin errors++; $display("FAIL br_cnt[%0d] got %0d want %0d", i, a_cnt, i + 1); end
            if (i == 7) a_valid = 1'b0;
            else        a_data  = 16'(i + 2);
        end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL br_ready_last got %0b want 0", a_ready); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL br_done_early got %0b want 0", a_done); end
        tick();
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL br_we_after got %0b want 0", a_we); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL br_done got %0b want 1", a_done); end
        checks++; if (a_cnt !== 9'd8) begin errors++; $display("FAIL br_cnt_done got %0d want 8", a_cnt); end
    endtask

    task automatic test_done_hold();
        a_valid = 1'b1;
        a_data  = 16'h0055;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %0b want 0", i, a_ready); end
            checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL hold_we[%0d] got %0b want 0", i, a_we); end
        end
        a_valid = 1'b0;
        a_ack   = 1'b1;
        tick();
        a_ack = 1'b0;
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL ack_done got %0b want 0", a_done); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL ack_busy got %0b want 0", a_busy); end
        checks++; if (a_cnt !== 9'd8) begin errors++; $display("FAIL ack_cnt got %0d want 8", a_cnt); end
        tick();
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %0b want 0", a_ready); end
    endtask

    task automatic test_random_gaps();
        int   sent;
        int   wr;
        int   cyc;
        logic rdy;
        logic v;
        sent = 0;
        wr   = 0;
        cyc  = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        while (cyc < 200 && !a_done) begin
            rdy     = a_ready;
            v       = (sent < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_valid = v;
            a_data  = 16'h0100 + 16'(sent);
            tick();
            if (v && rdy) sent++;
            if (a_we) begin
                if (wr < 8) begin
                    checks++; if (a_waddr !== 8'(exp_addr[wr])) begin errors++; $display("FAIL gap_addr[%0d] got %0d want %0d", wr, a_waddr, exp_addr[wr]); end
                    checks++; if (a_wdata !== 16'h0100 + 16'(wr)) begin errors++; $display("FAIL gap_data[%0d] got %0h want %0h", wr, a_wdata, 16'h0100 + 16'(wr)); end
                end
                wr++;
            end
            cyc++;
        end
        a_valid = 1'b0;
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL gap_timeout done got %0b want 1", a_done); end
        checks++; if (wr !== 8) begin errors++; $display("FAIL gap_writes got %0d want 8", wr); end
        checks++; if (a_cnt !== 9'd8) begin errors++; $display("FAIL gap_cnt got %0d want 8", a_cnt); end
    endtask

    task automatic test_ack_start();
        a_ack   = 1'b1;
        a_start = 1'b1;
        tick();
        a_ack   = 1'b0;
        a_start = 1'b0;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL ackstart_busy got %0b want 1", a_busy); end
        checks++; if (a_cnt !== 9'd0) begin errors++; $display("FAIL ackstart_cnt got %0d want 0", a_cnt); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL ackstart_done got %0b want 0", a_done); end
    endtask

    task automatic test_start_in_fill();
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_start = (i == 3);
            a_data  = 16'h0200 + 16'(i);
            tick();
            checks++; if (a_waddr !== 8'(exp_addr[i])) begin errors++; $display("FAIL sif_addr[%0d] got %0d want %0d", i, a_waddr, exp_addr[i]); end
            checks++; if (a_cnt !== 9'(i + 1)) begin errors++; $display("FAIL sif_cnt[%0d] got %0d want %0d", i, a_cnt, i + 1); end
        end
        a_start = 1'b0;
        a_valid = 1'b0;
        tick();
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL sif_done got %0b want 1", a_done); end
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
    endtask

    task automatic test_base_natural();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_data = 16'h000A + 16'(i);
            tick();
            checks++; if (b_we !== 1'b1) begin errors++; $display("FAIL nat_we[%0d] got %0b want 1", i, b_we); end
            checks++; if (b_waddr !== 8'(16 + i)) begin errors++; $display("FAIL nat_addr[%0d] got %0d want %0d", i, b_waddr, 16 + i); end
            checks++; if (b_wdata !== 16'h000A + 16'(i)) begin errors++; $display("FAIL nat_data[%0d] got %0h want %0h", i, b_wdata, 16'h000A + 16'(i)); end
        end
        tick();
        checks++; if (b_we !== 1'b0) begin errors++; $display("FAIL nat_extra_we got %0b want 0", b_we); end
        checks++; if (b_waddr !== 8'd19) begin errors++; $display("FAIL nat_waddr_hold got %0d want 19", b_waddr); end
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL nat_done got %0b want 1", b_done); end
        checks++; if (b_cnt !== 9'd4) begin errors++; $display("FAIL nat_cnt got %0d want 4", b_cnt); end
        b_valid = 1'b0;
    endtask

    task automatic test_reset_midframe();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_data = 16'h0300 + 16'(i);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b want 0", a_we); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b want 0", a_ready); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", a_busy); end
        a_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %0b want 0", a_busy); end
        checks++; if (a_cnt !== 9'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", a_cnt); end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_valid = 1'b1;
        a_data  = 16'h0777;
        tick();
        a_valid = 1'b0;
        checks++; if (a_we !== 1'b1) begin errors++; $display("FAIL rst_new_we got %0b want 1", a_we); end
        checks++; if (a_waddr !== 8'd0) begin errors++; $display("FAIL rst_new_addr got %0d want 0", a_waddr); end
        checks++; if (a_wdata !== 16'h0777) begin errors++; $display("FAIL rst_new_data got %0h want 777", a_wdata); end
    endtask

    initial begin
        test_reset();
        test_bitrev_frame();
        test_done_hold();
        test_random_gaps();
        test_ack_start();
        test_start_in_fill();
        test_base_natural();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
